// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule FSM states, Rcon table
// and the RotWord helper.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  // Rcon is looked up from the round index rather than generated by doubling.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Control/data bundle between the inverse key schedule and its user.
interface aes_inv_key_schedule_if;
  logic         ld_key;
  logic [127:0] key_in;
  logic         next_req;
  logic [127:0] key_out;
  logic [3:0]   round;
  logic         key_valid;
  logic         busy;
  logic         last;

  modport master (
    output ld_key, key_in, next_req,
    input  key_out, round, key_valid, busy, last
  );

  modport slave (
    input  ld_key, key_in, next_req,
    output key_out, round, key_valid, busy, last
  );
endinterface

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four byte S-boxes side by side.
module aes_sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  sbox u_sbox3 (.din(din[31:24]), .dout(dout[31:24]));
  sbox u_sbox2 (.din(din[23:16]), .dout(dout[23:16]));
  sbox u_sbox1 (.din(din[15:8]),  .dout(dout[15:8]));
  sbox u_sbox0 (.din(din[7:0]),   .dout(dout[7:0]));
endmodule

// File: rtl/sbox.sv
// AES forward S-box, byte lookup from a constant table (entry 0 in the MSBs).
module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n lives at bit offset (255-n)*8, i.e. {~n, 3'b000}.
  always_comb begin
    dout = SBOX_TBL[{~din, 3'b000} +: 8];
  end
endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption key schedule: expands forward to the round-10 key after
// a load, then walks back one round key per next_req.
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  aes_inv_key_schedule_if.slave   bus
);

  state_t       state, state_nxt;
  logic [127:0] key_q, key_nxt;
  logic [3:0]   round_q, round_nxt;

  logic [31:0] a, b, c, d;
  logic [31:0] inv_b, inv_c, inv_d, inv_a;
  logic [31:0] fwd_a, fwd_b, fwd_c, fwd_d;
  logic [31:0] sw_sel, sw_in, sw_out, t;
  logic [3:0]  rcon_idx;

  assign {a, b, c, d} = key_q;

  // The inverse recurrence needs d' = d^c before the S-box, so one SubWord
  // is shared: it sees d while expanding and d' while walking backward.
  always_comb begin
    inv_d    = d ^ c;
    inv_c    = c ^ b;
    inv_b    = b ^ a;
    sw_sel   = (state == EXPAND) ? d : inv_d;
    sw_in    = rot_word(sw_sel);
    rcon_idx = (state == EXPAND) ? round_q + 4'd1 : round_q;
    t        = sw_out ^ {rcon(rcon_idx), 24'h0};
    inv_a    = a ^ t;
    fwd_a    = a ^ t;
    fwd_b    = b ^ fwd_a;
    fwd_c    = c ^ fwd_b;
    fwd_d    = d ^ fwd_c;
  end

  aes_sub_word u_sub_word (
    .din  (sw_in),
    .dout (sw_out)
  );

  // Next-state, next-key and next-round selection; ld_key has priority.
  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    round_nxt = round_q;
    if (bus.ld_key) begin
      state_nxt = EXPAND;
      key_nxt   = bus.key_in;
      round_nxt = '0;
    end else begin
      case (state)
        EXPAND: begin
          key_nxt   = {fwd_a, fwd_b, fwd_c, fwd_d};
          round_nxt = round_q + 4'd1;
          if (round_q == 4'(NR - 1)) state_nxt = READY;
        end
        READY: begin
          if (bus.next_req && round_q != '0) begin
            key_nxt   = {inv_a, inv_b, inv_c, inv_d};
            round_nxt = round_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, key and round registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state   <= state_nxt;
      key_q   <= key_nxt;
      round_q <= round_nxt;
    end
  end

  assign bus.key_out   = key_q;
  assign bus.round     = round_q;
  assign bus.key_valid = (state == READY);
  assign bus.busy      = (state == EXPAND);
  assign bus.last      = (state == READY) && (round_q == '0);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: known-answer table, corner sequences and
// randomized keys against a GF(2^8)-based key expansion model.
module tb_aes_inv_key_schedule;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_inv_key_schedule_if bus ();

  aes_inv_key_schedule dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk [11];

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [8];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] r1, r2, r3, r4;
      for (int w = 1; w < 256; w++)
        if (gmul(8'(v), 8'(w)) == 8'h01) inv = 8'(w);
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sb[v] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  // Textbook word-array key expansion; Rcon generated by xtime doubling.
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = key;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] key);
    bus.ld_key = 1'b1;
    bus.key_in = key;
    step();
    bus.ld_key = 1'b0;
  endtask

  task automatic req();
    bus.next_req = 1'b1;
    step();
    bus.next_req = 1'b0;
  endtask

  // Bounded wait for key_valid; returns cycles taken after the load edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.key_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, " key_out"},   bus.key_out, '0);
    chk({nm, " round"},     128'(bus.round), '0);
    chk({nm, " key_valid"}, 128'(bus.key_valid), '0);
    chk({nm, " busy"},      128'(bus.busy), '0);
    chk({nm, " last"},      128'(bus.last), '0);
  endtask

  initial begin
    int lat;
    int cur_round;
    logic [127:0] cur_key;

    reset        = 1'b1;
    bus.ld_key   = 1'b0;
    bus.next_req = 1'b0;
    bus.key_in   = '0;
    build_sbox();

    tbl[0] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1] = '{FIPS_KEY,  9, 128'hac7766f319fadc2128d12941575c006e};
    tbl[2] = '{FIPS_KEY,  1, 128'ha0fafe1788542cb123a339392a6c7605};
    tbl[3] = '{FIPS_KEY,  0, FIPS_KEY};
    tbl[4] = '{128'h0,   10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    tbl[5] = '{128'h0,    1, 128'h62636363626363636263636362636363};
    tbl[6] = '{128'h0,    0, 128'h0};
    tbl[7] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    // Reset held two cycles, then next_req in IDLE must do nothing.
    step();
    step();
    reset = 1'b0;
    check_idle_zero("reset");
    req();
    check_idle_zero("idle next_req");

    // Known-answer table: reload whenever the key changes or a higher round is needed.
    cur_key   = 'x;
    cur_round = -1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].key !== cur_key || tbl[i].rnd > cur_round) begin
        load(tbl[i].key);
        chk("load busy", 128'(bus.busy), 128'(1));
        chk("load round", 128'(bus.round), '0);
        wait_valid(lat);
        chk("load latency", 128'(lat), 128'(10));
        chk("ready round", 128'(bus.round), 128'(10));
        cur_key   = tbl[i].key;
        cur_round = 10;
      end
      for (int n = 0; n < 12 && cur_round > tbl[i].rnd; n++) begin
        req();
        cur_round--;
      end
      chk($sformatf("kat[%0d] round", i), 128'(bus.round), 128'(tbl[i].rnd));
      chk($sformatf("kat[%0d] key", i), bus.key_out, tbl[i].exp);
      chk($sformatf("kat[%0d] valid", i), 128'(bus.key_valid), 128'(1));
      if (tbl[i].rnd == 0) begin
        chk($sformatf("kat[%0d] last", i), 128'(bus.last), 128'(1));
        // Underflow: one more request at round 0 changes nothing.
        req();
        chk("underflow key", bus.key_out, tbl[i].exp);
        chk("underflow round", 128'(bus.round), '0);
        chk("underflow last", 128'(bus.last), 128'(1));
      end
    end

    // Restart during expansion: reload at round 5, full latency again.
    load(FIPS_KEY);
    for (int i = 0; i < 5; i++) step();
    chk("mid expand round", 128'(bus.round), 128'(5));
    load(128'h0);
    chk("restart round", 128'(bus.round), '0);
    chk("restart key", bus.key_out, '0);
    chk("restart busy", 128'(bus.busy), 128'(1));
    wait_valid(lat);
    chk("restart latency", 128'(lat), 128'(10));
    chk("restart rk10", bus.key_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // ld_key and next_req together in READY: reload wins.
    bus.ld_key   = 1'b1;
    bus.next_req = 1'b1;
    bus.key_in   = FIPS_KEY;
    step();
    bus.ld_key   = 1'b0;
    bus.next_req = 1'b0;
    chk("ld+req round", 128'(bus.round), '0);
    chk("ld+req key", bus.key_out, FIPS_KEY);
    chk("ld+req busy", 128'(bus.busy), 128'(1));
    chk("ld+req valid", 128'(bus.key_valid), '0);

    // Reset mid-expansion, then reset overriding a simultaneous load.
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_zero("reset mid expand");
    reset      = 1'b1;
    bus.ld_key = 1'b1;
    bus.key_in = FIPS_KEY;
    step();
    reset      = 1'b0;
    bus.ld_key = 1'b0;
    check_idle_zero("reset over ld_key");

    // Random keys with random request spacing against the reference model.
    for (int k = 0; k < 200; k++) begin
      logic [127:0] key;
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      load(key);
      wait_valid(lat);
      chk("rand latency", 128'(lat), 128'(10));
      chk("rand rk10", bus.key_out, rk[10]);
      for (int r = 9; r >= 0; r--) begin
        int gap;
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) step();
        if (gap != 0) chk("rand hold", bus.key_out, rk[r+1]);
        req();
        chk($sformatf("rand k%0d r%0d", k, r), bus.key_out, rk[r]);
        chk("rand round", 128'(bus.round), 128'(r));
        chk("rand valid", 128'(bus.key_valid), 128'(1));
      end
      chk("rand last", 128'(bus.last), 128'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Decryption-side AES-128 key schedule: delivers round keys in reverse order (round 10 down to round 0) for the inverse-cipher datapath. On load it expands the cipher key forward, one round per cycle, to reach the round-10 key. It then steps backward one round key per request using the inverse recurrence. It sits beside the inverse-round datapath, exactly as the forward key schedule sits beside the encryption datapath.

## Interface
- NR, 10: number of AES-128 rounds. Fixed; other values are unsupported.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_key  in  1  single-cycle pulse; samples key_in and starts forward expansion.
- key_in  in  128  cipher key. Word w0 is bits [127:96].
- next_req  in  1  single-cycle pulse; requests the previous round key.
- key_out  out  128  current round key, registered.
- round  out  4  round index of key_out (0..10), registered.
- key_valid  out  1  key_out is a usable round key.
- busy  out  1  forward expansion in progress.
- last  out  1  key_valid and round==0; no further keys are available.

## Operation
- States:
  - IDLE: after reset.
  - EXPAND: forward expansion in progress.
  - READY: a round key is presented.
- Forward step, with key = {a,b,c,d} and next round index r:
  - t = SubWord(RotWord(d)) ^ {Rcon[r],24'h0}
  - a' = a^t, b' = b^a', c' = c^b', d' = d^c'
- Inverse step from round r to round r-1:
  - d' = d^c, c' = c^b, b' = b^a
  - a' = a ^ SubWord(RotWord(d')) ^ {Rcon[r],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Rcon is indexed from the round counter, never computed by doubling.
- A single SubWord instance is shared by both steps. Its input mux selects d in EXPAND and d' in READY.
- IDLE: ld_key moves to EXPAND with key_out=key_in and round=0. next_req is ignored.
- EXPAND: each cycle applies the forward step and increments round.
  - On the cycle where round becomes 10, the next state is READY.
  - next_req is ignored.
- READY:
  - next_req with round>0 applies the inverse step and decrements round.
  - next_req with round==0 is ignored; key_out is held.
- ld_key in any state, including mid-EXPAND, restarts: key_out=key_in, round=0, state EXPAND.
- ld_key and next_req asserted together: ld_key wins.
- Outputs:
  - key_valid = (state==READY).
  - busy = (state==EXPAND).
  - last = key_valid && round==0.
- Reset values: state IDLE, key_out 0, round 0, key_valid 0, busy 0, last 0.
- Reset overrides ld_key and next_req in the same cycle.
- round never exceeds 10 and never wraps below 0.

## Timing
- ld_key high at edge E:
  - busy=1 and round=0 after E.
  - round=k after E+k.
  - After E+10: round=10, key_valid=1, busy=0.
  - Load-to-valid latency is 10 cycles.
- next_req high at edge E while in READY with round>0: key_out and round update after E. key_valid stays 1; there is no bubble.
- Back-to-back next_req pulses yield one key per cycle.
- The inverse step is combinational within one cycle. Critical path: 32-bit XOR → sbox → two XORs.

## Structure
- Shared package aes_pkg holds:
  - Rcon table, as a function rcon(round[3:0]) returning 8 bits.
  - NR constant.
  - State enum {IDLE, EXPAND, READY}.
  - rot_word function.
- Sub-module aes_sub_word: 32-bit SubWord built from four instances of the existing sbox module. The forward key schedule reuses it as well.
- This block contains the FSM, the 128-bit key register, the 4-bit round counter, and the forward/inverse step logic.

## Test plan
- Reset: reset held for 2 cycles → key_out=0, round=0, key_valid=0, busy=0, last=0. next_req during IDLE → no change.
- FIPS-197 A.1 load: ld_key with key_in=2b7e151628aed2a6abf7158809cf4f3c → busy for 10 cycles. Then key_valid=1, round=10, key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reverse walk: 10 consecutive next_req pulses →
  - round 9: ac7766f319fadc2128d12941575c006e
  - round 1: a0fafe1788542cb123a339392a6c7605
  - round 0: 2b7e151628aed2a6abf7158809cf4f3c, with last=1.
- Underflow: extra next_req at round 0 → key_out and round unchanged, last stays 1.
- Restart and priority:
  - ld_key at expansion cycle 5 → round returns to 0 and the full 10-cycle latency restarts.
  - ld_key and next_req together in READY → reload only.
  - reset mid-EXPAND → IDLE with all outputs 0.
- Random regression: 200 random keys, each with random next_req spacing → every key_out matches a reference model's forward expansion, read in reverse order.
